// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data width, default bit timing.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 10;
    localparam int unsigned TIMER_W              = 8;
    localparam int unsigned BIT_IDX_W            = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    typedef logic [DATA_BITS-1:0] uart_byte_t;

    // True when idx addresses the final (MSB) data bit of a frame.
    function automatic logic is_last_bit(input logic [BIT_IDX_W-1:0] idx);
        return idx == BIT_IDX_W'(DATA_BITS - 1);
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Transmit-side handshake and serial line bundle.
//   tx_data    : byte to send, sampled on acceptance
//   tx_start   : send request, level-sampled each clock
//   serial_out : serial line, idle high
//   tx_busy    : frame in progress
//   tx_done    : one-cycle frame-complete pulse
// master = request source, slave = transmitter.
interface uart_transmitter_if import uart_pkg::*; ();

    uart_byte_t tx_data;
    logic       tx_start;
    logic       serial_out;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_data,
        output tx_start,
        input  serial_out,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output serial_out,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/tx_timer.sv
// Bit timer: counts 1..ROLL while enabled, wrapping back to 1.
//   clk, n_rst : clock, async active-low reset
//   clear      : load count 1 (first cycle of a new bit); overrides en
//   en         : advance the count
//   rollover   : registered, high during the cycle the count sits at ROLL
module tx_timer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ROLL  = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic en,
    output logic rollover
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ROLL_V   = WIDTH'(ROLL);
    localparam logic [WIDTH-1:0] ROLL_PRE = WIDTH'(ROLL - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             roll_q, roll_d;

    // Flag is raised one edge ahead so it lines up with count == ROLL.
    always_comb begin
        cnt_d  = cnt_q;
        roll_d = 1'b0;
        if (clear) begin
            cnt_d = ONE;
        end else if (en) begin
            cnt_d  = (cnt_q == ROLL_V) ? ONE : cnt_q + ONE;
            roll_d = (cnt_q == ROLL_PRE);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q  <= '0;
            roll_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            roll_q <= roll_d;
        end
    end

    assign rollover = roll_q;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1 frames (start 0, 8 data LSB first, stop 1).
//   clk, n_rst : clock, async active-low reset
//   bus        : uart_transmitter_if.slave (tx_data, tx_start in;
//                serial_out, tx_busy, tx_done out, all registered)
// A request is accepted only in IDLE; the byte is latched at acceptance
// and serial_out/tx_busy change on that same edge.
module uart_transmitter import uart_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                clk,
    input  logic                n_rst,
    uart_transmitter_if.slave   bus
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 255) begin : g_bad_param
        $error("uart_transmitter: CLKS_PER_BIT must be in 2..255");
    end

    uart_state_e            state_q, state_d;
    uart_byte_t             shift_q, shift_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic                   serial_q, serial_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   accept_c;
    logic                   timer_en_c;
    logic                   bit_end;

    assign timer_en_c = (state_q != IDLE);

    tx_timer #(
        .WIDTH (TIMER_W),
        .ROLL  (CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (accept_c),
        .en       (timer_en_c),
        .rollover (bit_end)
    );

    // Next-state and next-output logic; outputs are computed here so
    // they reach the pins straight from flops.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        serial_d  = serial_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        accept_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (bus.tx_start) begin
                    accept_c  = 1'b1;
                    state_d   = START;
                    shift_d   = bus.tx_data;
                    bit_idx_d = '0;
                    serial_d  = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d  = DATA;
                    serial_d = shift_q[0];
                end
            end

            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    if (is_last_bit(bit_idx_q)) begin
                        state_d  = STOP;
                        serial_d = 1'b1;
                    end else begin
                        serial_d = shift_q[1];
                    end
                end
            end

            STOP: begin
                // tx_start is not looked at here, so a request during the
                // final stop cycle is dropped rather than queued.
                if (bit_end) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    serial_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            serial_q  <= serial_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.serial_out = serial_q;
    assign bus.tx_busy    = busy_q;
    assign bus.tx_done    = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter; two instances (10 and 2 clocks/bit).
module tb_uart_transmitter;

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    uart_transmitter_if bus10 ();
    uart_transmitter_if bus2 ();

    uart_transmitter #(.CLKS_PER_BIT(10)) dut10 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus10.slave)
    );

    uart_transmitter #(.CLKS_PER_BIT(2)) dut2 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus2.slave)
    );

    int errors = 0;
    int checks = 0;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for frame bit idx: 0 start, 1..8 data LSB first, 9 stop.
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 1 && idx <= 8) return d[idx-1];
        return 1'b1;
    endfunction

    task automatic test_reset();
        logic [2:0] got;
        n_rst          = 1'b0;
        bus10.tx_start = 1'b1;
        bus10.tx_data  = 8'h5A;
        bus2.tx_start  = 1'b0;
        bus2.tx_data   = 8'h00;
        tick();
        tick();
        got = {bus10.serial_out, bus10.tx_busy, bus10.tx_done};
        checks++;
        if (got !== 3'b100) begin
            errors++;
            $display("FAIL reset_idle_10: {serial,busy,done}=%b expected 100", got);
        end
        got = {bus2.serial_out, bus2.tx_busy, bus2.tx_done};
        checks++;
        if (got !== 3'b100) begin
            errors++;
            $display("FAIL reset_idle_2: {serial,busy,done}=%b expected 100", got);
        end
        // Release mid-cycle with tx_start already high: first edge accepts.
        #2 n_rst = 1'b1;
        #1;
        got = {bus10.serial_out, bus10.tx_busy, bus10.tx_done};
        checks++;
        if (got !== 3'b100) begin
            errors++;
            $display("FAIL reset_release_pre_edge: {serial,busy,done}=%b expected 100", got);
        end
        tick();
        got = {bus10.serial_out, bus10.tx_busy, bus10.tx_done};
        checks++;
        if (got !== 3'b010) begin
            errors++;
            $display("FAIL first_edge_accept: {serial,busy,done}=%b expected 010", got);
        end
        bus10.tx_start = 1'b0;
    endtask

    // Continues the 8'h5A frame started above, then resets inside DATA.
    task automatic test_reset_abort();
        logic [2:0] got, exp;
        for (int n = 1; n <= 35; n++) begin
            tick();
            got = {bus10.serial_out, bus10.tx_busy, bus10.tx_done};
            exp = {frame_bit(8'h5A, n / 10), 1'b1, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pre_abort cycle %0d: {serial,busy,done}=%b expected %b", n, got, exp);
            end
        end
        #2 n_rst = 1'b0;
        #1;
        got = {bus10.serial_out, bus10.tx_busy, bus10.tx_done};
        checks++;
        if (got !== 3'b100) begin
            errors++;
            $display("FAIL abort_immediate: {serial,busy,done}=%b expected 100", got);
        end
        for (int n = 0; n < 3; n++) begin
            tick();
            got = {bus10.serial_out, bus10.tx_busy, bus10.tx_done};
            checks++;
            if (got !== 3'b100) begin
                errors++;
                $display("FAIL abort_hold cycle %0d: {serial,busy,done}=%b expected 100", n, got);
            end
        end
        #2 n_rst = 1'b1;
        for (int n = 0; n < 120; n++) begin
            tick();
            got = {bus10.serial_out, bus10.tx_busy, bus10.tx_done};
            checks++;
            if (got !== 3'b100) begin
                errors++;
                $display("FAIL abort_no_done cycle %0d: {serial,busy,done}=%b expected 100", n, got);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [2:0] got, exp;
        bus10.tx_data  = 8'hA5;
        bus10.tx_start = 1'b1;
        tick();
        bus10.tx_start = 1'b0;
        for (int n = 0; n <= 101; n++) begin
            if (n < 100)       exp = {frame_bit(8'hA5, n / 10), 1'b1, 1'b0};
            else if (n == 100) exp = 3'b101;
            else               exp = 3'b100;
            got = {bus10.serial_out, bus10.tx_busy, bus10.tx_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single_a5 cycle %0d: {serial,busy,done}=%b expected %b", n, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_busy_reject();
        logic [2:0] got, exp;
        bus10.tx_data  = 8'h3C;
        bus10.tx_start = 1'b1;
        tick();
        bus10.tx_start = 1'b0;
        for (int n = 0; n <= 130; n++) begin
            if (n < 100)       exp = {frame_bit(8'h3C, n / 10), 1'b1, 1'b0};
            else if (n == 100) exp = 3'b101;
            else               exp = 3'b100;
            got = {bus10.serial_out, bus10.tx_busy, bus10.tx_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL busy_reject cycle %0d: {serial,busy,done}=%b expected %b", n, got, exp);
            end
            // Requests in DATA and in the final STOP cycle must be dropped.
            if (n == 25 || n == 99) begin
                bus10.tx_start = 1'b1;
                bus10.tx_data  = 8'hFF;
            end else begin
                bus10.tx_start = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] got, exp;
        bus10.tx_data  = 8'h00;
        bus10.tx_start = 1'b1;
        tick();
        bus10.tx_data  = 8'hFF;
        for (int n = 0; n <= 203; n++) begin
            if (n < 100)       exp = {frame_bit(8'h00, n / 10), 1'b1, 1'b0};
            else if (n == 100) exp = 3'b101;
            else if (n <= 200) exp = {frame_bit(8'hFF, (n - 101) / 10), 1'b1, 1'b0};
            else if (n == 201) exp = 3'b101;
            else               exp = 3'b100;
            got = {bus10.serial_out, bus10.tx_busy, bus10.tx_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: {serial,busy,done}=%b expected %b", n, got, exp);
            end
            if (n == 101) bus10.tx_start = 1'b0;
            tick();
        end
    endtask

    task automatic test_data_hold();
        logic [2:0] got, exp;
        bus10.tx_data  = 8'h81;
        bus10.tx_start = 1'b1;
        tick();
        bus10.tx_start = 1'b0;
        for (int n = 0; n <= 101; n++) begin
            if (n < 100)       exp = {frame_bit(8'h81, n / 10), 1'b1, 1'b0};
            else if (n == 100) exp = 3'b101;
            else               exp = 3'b100;
            got = {bus10.serial_out, bus10.tx_busy, bus10.tx_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL data_hold cycle %0d: {serial,busy,done}=%b expected %b", n, got, exp);
            end
            bus10.tx_data = 8'(n * 37 + 3);
            tick();
        end
    endtask

    task automatic test_min_timing();
        logic [2:0] got, exp;
        bus2.tx_data  = 8'h55;
        bus2.tx_start = 1'b1;
        tick();
        bus2.tx_start = 1'b0;
        for (int n = 0; n <= 21; n++) begin
            if (n < 20)       exp = {frame_bit(8'h55, n / 2), 1'b1, 1'b0};
            else if (n == 20) exp = 3'b101;
            else              exp = 3'b100;
            got = {bus2.serial_out, bus2.tx_busy, bus2.tx_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL min_timing cycle %0d: {serial,busy,done}=%b expected %b", n, got, exp);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_reset_abort();
        test_single_frame();
        test_busy_reject();
        test_back_to_back();
        test_data_hold();
        test_min_timing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
